// File: rtl/lane_serializer.sv
// Wide-to-narrow lane serializer: takes one IN_W-bit word per handshake and
// emits it as IN_W/OUT_W consecutive OUT_W-bit slices, streaming words gap-free.
module lane_serializer #(
  parameter int               IN_W      = 32,
  parameter int               OUT_W     = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [OUT_W-1:0] IDLE_FILL = '0
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [IN_W-1:0]  lane_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_out,
  output logic             busy
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CNT_W = $clog2(RATIO + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO);

  generate
    if ((IN_W % OUT_W) != 0 || IN_W < OUT_W) begin : g_bad_widths
      $error("lane_serializer: IN_W must be a positive integer multiple of OUT_W");
    end
  endgenerate

  // Handshake: a transfer happens on any rising edge where valid and ready are
  // both high. Upstream: valid_in/ready_in; downstream: valid_out/ready_out.
  // valid_out never drops while a word is in flight, regardless of ready_out.

  logic [IN_W-1:0]  word_q, word_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic advance;
  logic last_sent;

  function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0]  word,
                                                input logic [CNT_W-1:0] k);
    int sh;
    if (MSB_FIRST) sh = (RATIO - 1 - int'(k)) * OUT_W;
    else           sh = int'(k) * OUT_W;
    return OUT_W'(word >> sh);
  endfunction

  assign last_sent = (cnt_q == LAST);
  // The last slice being consumed frees the buffer, so a new word can follow it
  // without a bubble.
  assign ready_in  = !valid_q || (ready_out && last_sent);
  assign accept    = valid_in && ready_in;
  assign advance   = valid_q && ready_out;

  always_comb begin
    word_d  = word_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (accept) begin
      word_d  = lane_in;
      data_d  = slice_of(lane_in, '0);
      valid_d = 1'b1;
      cnt_d   = CNT_W'(1);
    end else if (advance) begin
      if (!last_sent) begin
        data_d = slice_of(word_q, cnt_q);
        cnt_d  = cnt_q + CNT_W'(1);
      end else begin
        data_d  = IDLE_FILL;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      word_q  <= '0;
      data_q  <= IDLE_FILL;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy      = valid_q;

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: three configurations (32->8 MSB first, 32->8 LSB
// first, 64->16 MSB first) checked against a slice-queue reference model.
module tb_lane_serializer;

  logic clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  logic        reset;
  logic [63:0] lane;
  logic        ready_out;
  logic [2:0]  vin;

  logic [7:0]  d_a, d_b;
  logic [15:0] d_c;
  logic        vo_a, vo_b, vo_c;
  logic        ri_a, ri_b, ri_c;
  logic        bz_a, bz_b, bz_c;

  lane_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1), .IDLE_FILL(8'hBC)) u_a (
    .clk_4f(clk_4f), .reset(reset), .lane_in(lane[31:0]), .valid_in(vin[0]),
    .ready_in(ri_a), .data_out(d_a), .valid_out(vo_a), .ready_out(ready_out), .busy(bz_a));

  lane_serializer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0), .IDLE_FILL(8'hBC)) u_b (
    .clk_4f(clk_4f), .reset(reset), .lane_in(lane[31:0]), .valid_in(vin[1]),
    .ready_in(ri_b), .data_out(d_b), .valid_out(vo_b), .ready_out(ready_out), .busy(bz_b));

  lane_serializer #(.IN_W(64), .OUT_W(16), .MSB_FIRST(1'b1), .IDLE_FILL(16'hBCBC)) u_c (
    .clk_4f(clk_4f), .reset(reset), .lane_in(lane), .valid_in(vin[2]),
    .ready_in(ri_c), .data_out(d_c), .valid_out(vo_c), .ready_out(ready_out), .busy(bz_c));

  // Active-configuration selection and its parameters for the model.
  int          sel;
  int          in_w, out_w;
  bit          msb;
  logic [15:0] fill;

  logic [15:0] obs_data;
  logic        obs_valid, obs_ready, obs_busy;

  always_comb begin
    obs_data  = '0;
    obs_valid = 1'b0;
    obs_ready = 1'b0;
    obs_busy  = 1'b0;
    case (sel)
      0: begin obs_data = {8'h00, d_a}; obs_valid = vo_a; obs_ready = ri_a; obs_busy = bz_a; end
      1: begin obs_data = {8'h00, d_b}; obs_valid = vo_b; obs_ready = ri_b; obs_busy = bz_b; end
      default: begin obs_data = d_c; obs_valid = vo_c; obs_ready = ri_c; obs_busy = bz_c; end
    endcase
  end

  logic [15:0] exp_q[$];
  logic [15:0] out_log[$];
  logic [15:0] lit[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic select_cfg(input int s);
    sel = s;
    case (s)
      0: begin in_w = 32; out_w = 8;  msb = 1'b1; fill = 16'h00BC; end
      1: begin in_w = 32; out_w = 8;  msb = 1'b0; fill = 16'h00BC; end
      default: begin in_w = 64; out_w = 16; msb = 1'b1; fill = 16'hBCBC; end
    endcase
  endtask

  // A word turns into in_w/out_w slices, ordered from the top or bottom.
  task automatic push_word(input logic [63:0] w);
    logic [63:0] sh;
    logic [63:0] mask;
    mask = (64'd1 << out_w) - 64'd1;
    for (int k = 0; k < in_w / out_w; k++) begin
      if (msb) sh = w >> (in_w - (k + 1) * out_w);
      else     sh = w >> (k * out_w);
      exp_q.push_back(16'(sh & mask));
    end
  endtask

  // Drive one cycle's inputs, check outputs against the model, take the edge.
  task automatic cycle(input logic v, input logic [63:0] w, input logic r);
    logic exp_rdy, acc, adv;
    vin = '0;
    vin[sel] = v;
    lane = w;
    ready_out = r;
    #1;
    exp_rdy = (exp_q.size() == 0) || (r && exp_q.size() == 1);
    chk("ready_in",  64'(obs_ready), 64'(exp_rdy));
    chk("valid_out", 64'(obs_valid), 64'(exp_q.size() != 0));
    chk("data_out",  64'(obs_data),  64'((exp_q.size() != 0) ? exp_q[0] : fill));
    chk("busy",      64'(obs_busy),  64'(exp_q.size() != 0));
    if (obs_valid && r) out_log.push_back(obs_data);
    acc = v && exp_rdy;
    adv = (exp_q.size() != 0) && r;
    @(posedge clk_4f);
    if (adv) void'(exp_q.pop_front());
    if (acc) push_word(w);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 64'h0, 1'b1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 64'(out_log.size()), 64'(lit.size()));
    for (int i = 0; i < lit.size(); i++)
      chk(tag, (i < out_log.size()) ? 64'(out_log[i]) : 64'bx, 64'(lit[i]));
  endtask

  initial begin
    sel = 0;
    select_cfg(0);
    vin = '0;
    lane = '0;
    ready_out = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_valid_a", 64'(vo_a), 64'd0);
    chk("rst_data_a",  64'(d_a),  64'hBC);
    chk("rst_busy_a",  64'(bz_a), 64'd0);
    chk("rst_data_b",  64'(d_b),  64'hBC);
    chk("rst_valid_c", 64'(vo_c), 64'd0);
    chk("rst_data_c",  64'(d_c),  64'hBCBC);
    repeat (3) @(posedge clk_4f);
    #1 reset = 1'b1;

    // Idle after reset.
    select_cfg(0);
    idle(4);

    // Single word, MSB first.
    out_log.delete();
    cycle(1'b1, 64'hAABBCCDD, 1'b1);
    idle(5);
    lit = '{16'hAA, 16'hBB, 16'hCC, 16'hDD};
    check_log("msb_single");

    // Back-to-back words, LSB first.
    select_cfg(1);
    out_log.delete();
    cycle(1'b1, 64'h11223344, 1'b1);
    idle(3);
    cycle(1'b1, 64'hFFCCFFCC, 1'b1);
    idle(5);
    lit = '{16'h44, 16'h33, 16'h22, 16'h11, 16'hCC, 16'hFF, 16'hCC, 16'hFF};
    check_log("lsb_b2b");

    // Backpressure during slice 02; valid_in held high while stalled.
    select_cfg(0);
    out_log.delete();
    cycle(1'b1, 64'h01020304, 1'b1);
    cycle(1'b0, 64'h0, 1'b1);
    repeat (3) cycle(1'b1, 64'hDEADBEEF, 1'b0);
    idle(4);
    lit = '{16'h01, 16'h02, 16'h03, 16'h04};
    check_log("bp");

    // Asynchronous reset in the middle of a word.
    out_log.delete();
    cycle(1'b1, 64'hAABBCCDD, 1'b1);
    cycle(1'b0, 64'h0, 1'b1);
    cycle(1'b0, 64'h0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(vo_a), 64'd0);
    chk("midrst_data",  64'(d_a),  64'hBC);
    chk("midrst_ready", 64'(ri_a), 64'd1);
    exp_q.delete();
    @(posedge clk_4f);
    #1 reset = 1'b1;
    out_log.delete();
    cycle(1'b1, 64'h00000003, 1'b1);
    idle(5);
    lit = '{16'h00, 16'h00, 16'h00, 16'h03};
    check_log("after_rst");

    // Wide configuration.
    select_cfg(2);
    out_log.delete();
    cycle(1'b1, 64'h0123456789ABCDEF, 1'b1);
    idle(5);
    lit = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    check_log("wide");

    // Randomized traffic with random backpressure on every configuration.
    for (int s = 0; s < 3; s++) begin
      select_cfg(s);
      for (int i = 0; i < 200; i++)
        cycle($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      idle(6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
